raster_marker_gen: RTL and testbench

- Transmit-side companion to the horizontal edge detector.
- Takes a raw pixel stream plus a frame-start pulse and produces the registered raster-scan stream that the filter pipeline consumes.
- Output stream carries valid, data and position markers: first column (col1), last column (colN), first row (row1) and last row (rowM).
- Frame dimensions are latched at frame start. Protocol violations are flagged on a sticky error output.

---
 rtl/raster_marker_gen_if.sv | 36 +++
 rtl/raster_marker_gen.sv | 148 ++++++++++++++
 tb/tb_raster_marker_gen.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_marker_gen_if.sv
// Handshake bundle for raster_marker_gen: raw pixel stream and frame control in,
// registered raster-scan stream with position markers out.
interface raster_marker_gen_if #(
  parameter int DW = 8,
  parameter int XB = 10,
  parameter int YB = 10
);
  logic          i_start;
  logic [XB-1:0] i_ncols;
  logic [YB-1:0] i_nrows;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          i_clr_err;

  logic          o_valid_data;
  logic [DW-1:0] o_data;
  logic          o_col1;
  logic          o_colN;
  logic          o_row1;
  logic          o_rowM;
  logic          o_frame_done;
  logic          o_busy;
  logic          o_err;

  modport master (
    output i_start, i_ncols, i_nrows, i_valid, i_data, i_clr_err,
    input  o_valid_data, o_data, o_col1, o_colN, o_row1, o_rowM,
           o_frame_done, o_busy, o_err
  );

  modport slave (
    input  i_start, i_ncols, i_nrows, i_valid, i_data, i_clr_err,
    output o_valid_data, o_data, o_col1, o_colN, o_row1, o_rowM,
           o_frame_done, o_busy, o_err
  );
endinterface

// File: rtl/raster_marker_gen.sv
// Raster-scan marker generator: tags each accepted pixel with first/last column and
// row markers, pulses frame_done on the final pixel, and flags protocol errors.
module raster_marker_gen #(
  parameter int DW = 8,
  parameter int XB = 10,
  parameter int YB = 10
) (
  input  logic                clk,
  input  logic                rst,
  raster_marker_gen_if.slave  bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [XB-1:0] COL_ONE = XB'(1);
  localparam logic [XB-1:0] COL_MIN = XB'(2);
  localparam logic [YB-1:0] ROW_ONE = YB'(1);

  state_t        state, state_nxt;
  logic [XB-1:0] col, col_nxt;
  logic [YB-1:0] row, row_nxt;
  logic [XB-1:0] ncols_q, ncols_nxt;
  logic [YB-1:0] nrows_q, nrows_nxt;

  logic          start_legal;
  logic          beat;
  logic          err_set;
  logic [XB-1:0] eff_col, eff_ncols;
  logic [YB-1:0] eff_row, eff_nrows;
  logic          first_col, last_col, first_row, last_row, last_pix;

  assign start_legal = bus.i_start && (bus.i_ncols >= COL_MIN) && (bus.i_nrows != '0);

  // A beat accepted on the start cycle is pixel (0,0) of the frame being opened,
  // so its markers come from the live dimensions rather than the latched ones.
  assign eff_col   = (state == IDLE) ? '0          : col;
  assign eff_row   = (state == IDLE) ? '0          : row;
  assign eff_ncols = (state == IDLE) ? bus.i_ncols : ncols_q;
  assign eff_nrows = (state == IDLE) ? bus.i_nrows : nrows_q;

  assign first_col = (eff_col == '0);
  assign last_col  = (eff_col == eff_ncols - COL_ONE);
  assign first_row = (eff_row == '0);
  assign last_row  = (eff_row == eff_nrows - ROW_ONE);
  assign last_pix  = last_col && last_row;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    ncols_nxt = ncols_q;
    nrows_nxt = nrows_q;
    beat      = 1'b0;
    err_set   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.i_start && !start_legal) begin
          err_set = 1'b1;
        end
        if (start_legal) begin
          state_nxt = ACTIVE;
          ncols_nxt = bus.i_ncols;
          nrows_nxt = bus.i_nrows;
          col_nxt   = '0;
          row_nxt   = '0;
        end
        if (bus.i_valid) begin
          if (start_legal) begin
            beat = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ACTIVE: begin
        err_set = bus.i_start;
        beat    = bus.i_valid;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // ncols >= 2 guarantees a start-cycle beat never hits last_pix.
    if (beat) begin
      if (last_pix) begin
        state_nxt = IDLE;
        col_nxt   = '0;
        row_nxt   = '0;
      end else if (last_col) begin
        col_nxt = '0;
        row_nxt = eff_row + ROW_ONE;
      end else begin
        col_nxt = eff_col + COL_ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      col              <= '0;
      row              <= '0;
      ncols_q          <= '0;
      nrows_q          <= '0;
      bus.o_valid_data <= 1'b0;
      bus.o_data       <= '0;
      bus.o_col1       <= 1'b0;
      bus.o_colN       <= 1'b0;
      bus.o_row1       <= 1'b0;
      bus.o_rowM       <= 1'b0;
      bus.o_frame_done <= 1'b0;
      bus.o_busy       <= 1'b0;
      bus.o_err        <= 1'b0;
    end else begin
      state            <= state_nxt;
      col              <= col_nxt;
      row              <= row_nxt;
      ncols_q          <= ncols_nxt;
      nrows_q          <= nrows_nxt;
      bus.o_valid_data <= beat;
      if (beat) begin
        bus.o_data <= bus.i_data;
      end
      bus.o_col1       <= beat && first_col;
      bus.o_colN       <= beat && last_col;
      bus.o_row1       <= beat && first_row;
      bus.o_rowM       <= beat && last_row;
      bus.o_frame_done <= beat && last_pix;
      bus.o_busy       <= (state_nxt == ACTIVE);
      // A new violation outranks a simultaneous clear.
      if (err_set) begin
        bus.o_err <= 1'b1;
      end else if (bus.i_clr_err) begin
        bus.o_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_raster_marker_gen.sv
// Self-checking bench for raster_marker_gen: constant vector table, directed frames,
// async reset, maximum width, and random traffic against a pixel-index reference model.
module tb_raster_marker_gen;
  localparam int DW = 8;
  localparam int XB = 10;
  localparam int YB = 10;
  localparam int OW = DW + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  raster_marker_gen_if #(.DW(DW), .XB(XB), .YB(YB)) bus ();

  raster_marker_gen #(.DW(DW), .XB(XB), .YB(YB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: position is a flat pixel index within the frame.
  bit            m_active;
  int            m_idx, m_nc, m_nr;
  bit            m_err;
  logic [DW-1:0] m_data;
  logic [OW-1:0] m_exp;

  typedef struct {
    string         name;
    logic          start;
    int            ncols;
    int            nrows;
    logic          valid;
    logic [DW-1:0] data;
    logic          clr;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [OW-1:0] pack(input logic v, input logic [DW-1:0] d,
      input logic c1, input logic cn, input logic r1, input logic rm,
      input logic dn, input logic by, input logic er);
    return {v, d, c1, cn, r1, rm, dn, by, er};
  endfunction

  function automatic logic [OW-1:0] act_vec();
    return pack(bus.o_valid_data, bus.o_data, bus.o_col1, bus.o_colN, bus.o_row1,
                bus.o_rowM, bus.o_frame_done, bus.o_busy, bus.o_err);
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s t=%0t got={v,data,c1,cN,r1,rM,done,busy,err}=%h expected=%h",
               name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic st, input int nc, input int nr, input logic v,
                       input logic [DW-1:0] d, input logic clr);
    bus.i_start   = st;
    bus.i_ncols   = XB'(nc);
    bus.i_nrows   = YB'(nr);
    bus.i_valid   = v;
    bus.i_data    = d;
    bus.i_clr_err = clr;
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_idx    = 0;
    m_nc     = 0;
    m_nr     = 0;
    m_err    = 1'b0;
    m_data   = '0;
    m_exp    = '0;
  endtask

  task automatic model_step();
    bit set_err = 1'b0;
    bit v = 1'b0, c1 = 1'b0, cn = 1'b0, r1 = 1'b0, rm = 1'b0, dn = 1'b0;
    int c, r;
    if (!m_active) begin
      if (bus.i_start) begin
        if (int'(bus.i_ncols) >= 2 && int'(bus.i_nrows) >= 1) begin
          m_active = 1'b1;
          m_nc     = int'(bus.i_ncols);
          m_nr     = int'(bus.i_nrows);
          m_idx    = 0;
        end else begin
          set_err = 1'b1;
        end
      end
      if (bus.i_valid && !m_active) set_err = 1'b1;
    end else if (bus.i_start) begin
      set_err = 1'b1;
    end
    if (bus.i_valid && m_active) begin
      c      = m_idx % m_nc;
      r      = m_idx / m_nc;
      v      = 1'b1;
      m_data = bus.i_data;
      c1     = (c == 0);
      cn     = (c == m_nc - 1);
      r1     = (r == 0);
      rm     = (r == m_nr - 1);
      dn     = (m_idx == m_nc * m_nr - 1);
      m_idx++;
      if (dn) m_active = 1'b0;
    end
    if (set_err) m_err = 1'b1;
    else if (bus.i_clr_err) m_err = 1'b0;
    m_exp = pack(v, m_data, c1, cn, r1, rm, dn, m_active, m_err);
  endtask

  // One clock: model consumes the inputs present at the edge, outputs sampled 1 time unit later.
  task automatic step(input string name);
    @(posedge clk);
    model_step();
    #1;
    check(name, act_vec(), m_exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0, '0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", act_vec(), '0);
    rst = 1'b0;
  endtask

  task automatic add_vec(input string nm, input logic st, input int nc, input int nr,
                         input logic v, input logic [DW-1:0] d, input logic clr,
                         input logic [OW-1:0] exp);
    vec_t t;
    t.name = nm; t.start = st; t.ncols = nc; t.nrows = nr;
    t.valid = v; t.data = d; t.clr = clr; t.exp = exp;
    vq.push_back(t);
  endtask

  // Start a frame, then feed ncols*nrows beats with 'gap' idle cycles after each.
  task automatic run_frame(input string nm, input int nc, input int nr, input int gap,
                           output int done_cnt, output int done_data);
    done_cnt  = 0;
    done_data = -1;
    drive(1'b1, nc, nr, 1'b0, '0, 1'b0);
    step({nm, "_start"});
    for (int i = 0; i < nc * nr; i++) begin
      drive(1'b0, 0, 0, 1'b1, DW'(i), 1'b0);
      step({nm, "_beat"});
      if (bus.o_frame_done) begin
        done_cnt++;
        done_data = int'(bus.o_data);
      end
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 0, 0, 1'b0, '0, 1'b0);
        step({nm, "_gap"});
        if (bus.o_frame_done) done_cnt++;
      end
    end
    drive(1'b0, 0, 0, 1'b0, '0, 1'b0);
    step({nm, "_after"});
    if (bus.o_frame_done) done_cnt++;
  endtask

  initial begin
    int dcnt, ddata, beat_idx, done_idx;
    int coln_q[$];

    // Constant vectors: violations, clear, start-with-valid, back-to-back frames.
    add_vec("idle",          0, 0, 0, 0, 8'h00, 0, pack(0, 8'h00, 0,0,0,0,0,0,0));
    add_vec("ncols1",        1, 1, 3, 0, 8'h00, 0, pack(0, 8'h00, 0,0,0,0,0,0,1));
    add_vec("clr1",          0, 0, 0, 0, 8'h00, 1, pack(0, 8'h00, 0,0,0,0,0,0,0));
    add_vec("valid_idle",    0, 0, 0, 1, 8'h55, 0, pack(0, 8'h00, 0,0,0,0,0,0,1));
    add_vec("clr2",          0, 0, 0, 0, 8'h00, 1, pack(0, 8'h00, 0,0,0,0,0,0,0));
    add_vec("nrows0",        1, 4, 0, 0, 8'h00, 0, pack(0, 8'h00, 0,0,0,0,0,0,1));
    add_vec("start_valid",   1, 2, 1, 1, 8'hA0, 1, pack(1, 8'hA0, 1,0,1,1,0,1,0));
    add_vec("last_a",        0, 0, 0, 1, 8'hA1, 0, pack(1, 8'hA1, 0,1,1,1,1,0,0));
    add_vec("b2b_start",     1, 2, 1, 1, 8'hB0, 0, pack(1, 8'hB0, 1,0,1,1,0,1,0));
    add_vec("gap_hold",      0, 0, 0, 0, 8'hEE, 0, pack(0, 8'hB0, 0,0,0,0,0,1,0));
    add_vec("start_active",  1, 2, 1, 0, 8'h00, 0, pack(0, 8'hB0, 0,0,0,0,0,1,1));
    add_vec("set_beats_clr", 1, 2, 1, 0, 8'h00, 1, pack(0, 8'hB0, 0,0,0,0,0,1,1));
    add_vec("clr3",          0, 0, 0, 0, 8'h00, 1, pack(0, 8'hB0, 0,0,0,0,0,1,0));
    add_vec("last_b",        0, 0, 0, 1, 8'hB1, 1, pack(1, 8'hB1, 0,1,1,1,1,0,0));
    add_vec("post_frame",    0, 0, 0, 0, 8'h00, 0, pack(0, 8'hB1, 0,0,0,0,0,0,0));

    do_reset();
    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].ncols, vq[i].nrows, vq[i].valid, vq[i].data, vq[i].clr);
      @(posedge clk);
      #1;
      check({"vec_", vq[i].name}, act_vec(), vq[i].exp);
    end

    // Basic 4x3 frame, contiguous then with two-cycle gaps.
    do_reset();
    run_frame("basic", 4, 3, 0, dcnt, ddata);
    check_int("basic_done_count", dcnt, 1);
    check_int("basic_done_data", ddata, 11);
    run_frame("gaps", 4, 3, 2, dcnt, ddata);
    check_int("gaps_done_count", dcnt, 1);
    check_int("gaps_done_data", ddata, 11);

    // Start mid-frame is ignored; the frame still completes.
    drive(1'b1, 3, 1, 1'b0, '0, 1'b0);
    step("mid_start0");
    drive(1'b0, 0, 0, 1'b1, 8'h10, 1'b0);
    step("mid_beat0");
    drive(1'b1, 5, 5, 1'b1, 8'h11, 1'b0);
    step("mid_beat1_start");
    drive(1'b0, 0, 0, 1'b1, 8'h12, 1'b0);
    step("mid_beat2");
    check_int("mid_done", int'(bus.o_frame_done), 1);
    check_int("mid_err", int'(bus.o_err), 1);
    drive(1'b0, 0, 0, 1'b0, '0, 1'b1);
    step("mid_clr");

    // Async reset between edges in the middle of a frame.
    drive(1'b1, 4, 3, 1'b0, '0, 1'b0);
    step("arst_start");
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 0, 0, 1'b1, DW'(8'h40 + i), 1'b0);
      step("arst_beat");
    end
    #2 rst = 1'b1;
    #1 check("arst_immediate", act_vec(), '0);
    model_reset();
    @(posedge clk);
    #1 check("arst_held", act_vec(), '0);
    rst = 1'b0;
    run_frame("arst_after", 4, 3, 0, dcnt, ddata);
    check_int("arst_after_done", dcnt, 1);

    // Maximum width frame.
    beat_idx = 0;
    done_idx = -1;
    drive(1'b1, 1023, 2, 1'b0, '0, 1'b0);
    step("max_start");
    for (int i = 0; i < 2046; i++) begin
      drive(1'b0, 0, 0, 1'b1, DW'(i), 1'b0);
      step("max_beat");
      if (bus.o_valid_data) begin
        if (bus.o_colN) coln_q.push_back(beat_idx);
        if (bus.o_frame_done) done_idx = beat_idx;
        beat_idx++;
      end
    end
    drive(1'b0, 0, 0, 1'b0, '0, 1'b0);
    step("max_after");
    check_int("max_coln_count", coln_q.size(), 2);
    if (coln_q.size() == 2) begin
      check_int("max_coln_first", coln_q[0], 1022);
      check_int("max_coln_second", coln_q[1], 2045);
    end
    check_int("max_done_beat", done_idx, 2045);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic st, v, clr;
      st  = m_active ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
      v   = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 15) == 0);
      drive(st, $urandom_range(0, 6), $urandom_range(0, 4), v, DW'($urandom), clr);
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
